// File: rtl/regfile_window_if.sv
// regfile_window_if: register-file read ports, window beat handshake and scan control
interface regfile_window_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] rf_add1, rf_add2, rf_add3, rf_add4;
    logic [DATA_WIDTH-1:0] rf_data1, rf_data2, rf_data3, rf_data4;
    logic [DATA_WIDTH-1:0] win_data1, win_data2, win_data3, win_data4;
    logic [3:0]            win_row, win_col;
    logic                  win_valid;
    logic                  win_ready;
    modport master (
        input  start, rf_data1, rf_data2, rf_data3, rf_data4, win_ready,
        output busy, done, rf_add1, rf_add2, rf_add3, rf_add4,
               win_data1, win_data2, win_data3, win_data4, win_row, win_col, win_valid
    );
    modport slave (
        output start, rf_data1, rf_data2, rf_data3, rf_data4, win_ready,
        input  busy, done, rf_add1, rf_add2, rf_add3, rf_add4,
               win_data1, win_data2, win_data3, win_data4, win_row, win_col, win_valid
    );
endinterface

// File: rtl/regfile_window_reader.sv
// regfile_window_reader: scans a row-major tile as 2x2 stride-1 windows onto a valid/ready stream
module regfile_window_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int IMG_W      = 5,
    parameter int IMG_H      = 6
) (
    input logic clk,
    input logic nrst,
    regfile_window_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, next_state;
    logic [3:0]  fr, fc;
    logic        exhausted, load, last_fetch, row_end, hs;
    logic [15:0] base;
    assign base        = 16'(fr) * 16'(IMG_W) + 16'(fc);
    assign bus.rf_add1 = ADDR_WIDTH'(base);
    assign bus.rf_add2 = ADDR_WIDTH'(base + 16'd1);
    assign bus.rf_add3 = ADDR_WIDTH'(base + 16'(IMG_W));
    assign bus.rf_add4 = ADDR_WIDTH'(base + 16'(IMG_W) + 16'd1);
    assign hs          = bus.win_valid && bus.win_ready;
    assign load        = state == RUN && !exhausted && (!bus.win_valid || bus.win_ready);
    assign row_end     = fc == 4'(IMG_W - 2);
    assign last_fetch  = row_end && fr == 4'(IMG_H - 2);
    assign bus.busy    = state == RUN;
    assign bus.done    = state == DONE;
    always_comb begin
        next_state = state == IDLE ? (bus.start ? RUN : IDLE) :
                     state == RUN  ? (exhausted && hs ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state         <= IDLE;
            fr            <= '0;
            fc            <= '0;
            exhausted     <= 1'b0;
            bus.win_valid <= 1'b0;
            bus.win_row   <= '0;
            bus.win_col   <= '0;
            bus.win_data1 <= '0;
            bus.win_data2 <= '0;
            bus.win_data3 <= '0;
            bus.win_data4 <= '0;
        end else begin
            state <= next_state;
            if (load) begin
                bus.win_data1 <= bus.rf_data1;
                bus.win_data2 <= bus.rf_data2;
                bus.win_data3 <= bus.rf_data3;
                bus.win_data4 <= bus.rf_data4;
                bus.win_row   <= fr;
                bus.win_col   <= fc;
                bus.win_valid <= 1'b1;
                // counters return to window (0,0) once the final window is fetched
                fc            <= row_end ? '0 : fc + 4'd1;
                fr            <= last_fetch ? '0 : row_end ? fr + 4'd1 : fr;
                exhausted     <= last_fetch;
            end else if (hs) begin
                bus.win_valid <= 1'b0;
            end
            if (state == DONE) exhausted <= 1'b0;
        end
    end
endmodule
